// File: rtl/trace_capture_buffer.sv
// Circular execution-trace recorder: captures {cycle, pc, instruction, acc} per CPU cycle,
// freezes after a trigger plus a programmable post-trigger count, then streams entries oldest-first.
module trace_capture_buffer #(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_WIDTH = 16,
    parameter int ACC_WIDTH   = 8,
    parameter int CYCLE_WIDTH = 16,
    parameter int DEPTH       = 64,
    localparam int AW         = $clog2(DEPTH),
    localparam int ENTRY_W    = CYCLE_WIDTH + PC_WIDTH + INSTR_WIDTH + ACC_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sample_valid,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic [ACC_WIDTH-1:0]   acc,
    input  logic                   arm,
    input  logic                   trig_pc_en,
    input  logic [PC_WIDTH-1:0]    trig_pc,
    input  logic                   ext_trig,
    input  logic [AW-1:0]          post_count,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [ENTRY_W-1:0]     rd_data,
    output logic                   rd_last,
    output logic [2:0]             state,
    output logic [AW:0]            entry_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        POST    = 3'd2,
        DONE    = 3'd3,
        DRAIN   = 3'd4
    } state_e;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    state_e                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [AW-1:0]          post_cnt_q, post_cnt_d;
    logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   rd_last_q, rd_last_d;
    logic [ENTRY_W-1:0]     rd_data_q;

    logic [ENTRY_W-1:0]     mem [DEPTH];
    logic                   mem_we;
    logic [ENTRY_W-1:0]     mem_wdata;
    logic                   rd_load;
    logic [AW-1:0]          rd_addr;

    logic                   trigger;
    logic                   record;
    logic                   xfer;
    logic [AW-1:0]          oldest_ptr;
    logic [AW-1:0]          last_ptr;

    assign trigger    = sample_valid & ((trig_pc_en & (pc == trig_pc)) | ext_trig);
    assign record     = sample_valid & ~arm & ((state_q == CAPTURE) | (state_q == POST));
    assign xfer       = rd_valid_q & rd_ready;
    // A full buffer has count[AW-1:0]==0, so the oldest entry is the one about to be overwritten.
    assign oldest_ptr = wr_ptr_q - count_q[AW-1:0];
    assign last_ptr   = wr_ptr_q - AW'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            cycle_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            cycle_q    <= cycle_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = CAPTURE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                CAPTURE: if (trigger) state_d = (post_count == '0) ? DONE : POST;
                POST:    if (sample_valid && (post_cnt_q == AW'(1))) state_d = DONE;
                DONE:    if (count_q != '0) state_d = DRAIN;
                DRAIN:   if (xfer && rd_last_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        cycle_d    = sample_valid ? cycle_q + CYCLE_WIDTH'(1) : cycle_q;
        mem_we     = 1'b0;
        mem_wdata  = {cycle_q, pc, instruction, acc};
        rd_load    = 1'b0;
        rd_addr    = rd_ptr_q;

        if (arm) begin
            wr_ptr_d   = '0;
            count_d    = '0;
            post_cnt_d = '0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end else begin
            if (record) begin
                mem_we   = reset_n;
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (count_q != FULL_COUNT) count_d = count_q + (AW + 1)'(1);
            end
            unique case (state_q)
                CAPTURE: if (trigger) post_cnt_d = post_count;
                POST:    if (sample_valid) post_cnt_d = post_cnt_q - AW'(1);
                DONE: begin
                    if (count_q != '0) begin
                        rd_load    = 1'b1;
                        rd_addr    = oldest_ptr;
                        rd_ptr_d   = oldest_ptr;
                        rd_valid_d = 1'b1;
                        rd_last_d  = (oldest_ptr == last_ptr);
                    end
                end
                DRAIN: begin
                    // Fetch the next entry on the accepting edge so valid never bubbles.
                    if (xfer) begin
                        if (rd_last_q) begin
                            rd_valid_d = 1'b0;
                            rd_last_d  = 1'b0;
                            count_d    = '0;
                        end else begin
                            rd_load   = 1'b1;
                            rd_addr   = rd_ptr_q + AW'(1);
                            rd_ptr_d  = rd_addr;
                            rd_last_d = (rd_addr == last_ptr);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state       = state_q;
        rd_valid    = rd_valid_q;
        rd_last     = rd_last_q;
        rd_data     = rd_data_q;
        entry_count = count_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (rd_load) begin
            rd_data_q <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Randomized and directed bench for trace_capture_buffer; a queue-based reference model
// feeds an expected-entry scoreboard consumed by a separate output monitor.
module tb_trace_capture_buffer;

    localparam int PC_W    = 10;
    localparam int IW      = 16;
    localparam int ACC_W   = 8;
    localparam int CYC_W   = 16;
    localparam int DEPTH   = 64;
    localparam int AW      = 6;
    localparam int EW      = CYC_W + PC_W + IW + ACC_W;

    localparam int S_IDLE    = 0;
    localparam int S_CAPTURE = 1;
    localparam int S_POST    = 2;
    localparam int S_DONE    = 3;
    localparam int S_DRAIN   = 4;

    typedef logic [EW-1:0] entry_t;

    logic             clk;
    logic             reset_n;
    logic             sample_valid;
    logic [PC_W-1:0]  pc;
    logic [IW-1:0]    instruction;
    logic [ACC_W-1:0] acc;
    logic             arm;
    logic             trig_pc_en;
    logic [PC_W-1:0]  trig_pc;
    logic             ext_trig;
    logic [AW-1:0]    post_count;
    logic             rd_valid;
    logic             rd_ready;
    logic [EW-1:0]    rd_data;
    logic             rd_last;
    logic [2:0]       state;
    logic [AW:0]      entry_count;

    trace_capture_buffer #(
        .PC_WIDTH    (PC_W),
        .INSTR_WIDTH (IW),
        .ACC_WIDTH   (ACC_W),
        .CYCLE_WIDTH (CYC_W),
        .DEPTH       (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .pc           (pc),
        .instruction  (instruction),
        .acc          (acc),
        .arm          (arm),
        .trig_pc_en   (trig_pc_en),
        .trig_pc      (trig_pc),
        .ext_trig     (ext_trig),
        .post_count   (post_count),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .state        (state),
        .entry_count  (entry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: trace kept as a plain queue of at most DEPTH entries.
    entry_t           m_buf[$];
    entry_t           exp_q[$];
    int               m_state = S_IDLE;
    logic [CYC_W-1:0] m_stamp = '0;
    int               m_post  = 0;
    int               m_left  = 0;

    int               n_checks = 0;
    int               n_errors = 0;

    entry_t           held;
    entry_t           mon_exp;
    logic             hold_pending = 1'b0;
    logic             pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_record(input logic [CYC_W-1:0] stamp);
        m_buf.push_back({stamp, pc, instruction, acc});
        if (m_buf.size() > DEPTH) void'(m_buf.pop_front());
    endfunction

    // Advances the model by one clock using the inputs about to be sampled.
    function automatic void model_step();
        logic [CYC_W-1:0] stamp_now;
        logic             trig;
        stamp_now = m_stamp;
        if (!reset_n) begin
            m_state = S_IDLE;
            m_buf.delete();
            exp_q.delete();
            m_stamp = '0;
            m_post  = 0;
            m_left  = 0;
            return;
        end
        if (sample_valid) m_stamp = m_stamp + CYC_W'(1);
        trig = sample_valid && ((trig_pc_en && (pc == trig_pc)) || ext_trig);
        if (arm) begin
            m_buf.delete();
            exp_q.delete();
            m_state = S_CAPTURE;
            return;
        end
        case (m_state)
            S_CAPTURE: begin
                if (sample_valid) begin
                    model_record(stamp_now);
                    if (trig) begin
                        if (post_count == '0) m_state = S_DONE;
                        else begin
                            m_post  = int'(post_count);
                            m_state = S_POST;
                        end
                    end
                end
            end
            S_POST: begin
                if (sample_valid) begin
                    model_record(stamp_now);
                    m_post--;
                    if (m_post == 0) m_state = S_DONE;
                end
            end
            S_DONE: begin
                if (m_buf.size() > 0) begin
                    foreach (m_buf[i]) exp_q.push_back(m_buf[i]);
                    m_left  = m_buf.size();
                    m_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rd_ready) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_state = S_IDLE;
                        m_buf.delete();
                    end
                end
            end
            default: m_state = S_IDLE;
        endcase
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("state", 64'(state), 64'(m_state));
        chk("entry_count", 64'(entry_count), 64'(m_buf.size()));
        chk("rd_valid", 64'(rd_valid), 64'(m_state == S_DRAIN));
    endtask

    task automatic rand_payload();
        instruction = IW'($urandom);
        acc         = ACC_W'($urandom);
    endtask

    task automatic quiet_inputs();
        sample_valid = 1'b0;
        arm          = 1'b0;
        ext_trig     = 1'b0;
        rd_ready     = 1'b0;
        pc           = '0;
        rand_payload();
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic drain(input int mode);
        int k;
        k = 0;
        while (m_state != S_IDLE && k < 1000) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = pat[k % 4];
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            sample_valid = 1'($urandom_range(0, 1));
            ext_trig     = 1'($urandom_range(0, 1));
            pc           = PC_W'($urandom_range(0, 40));
            rand_payload();
            tick();
            k++;
        end
        quiet_inputs();
        if (m_state != S_IDLE) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got model state %0d after %0d cycles expected %0d", m_state, k, S_IDLE);
        end
    endtask

    task automatic arm_pulse();
        arm      = 1'b1;
        rd_ready = 1'b0;
        tick();
        arm      = 1'b0;
    endtask

    task automatic sample(input int p, input logic ext);
        sample_valid = 1'b1;
        pc           = PC_W'(p);
        ext_trig     = ext;
        rand_payload();
        tick();
        sample_valid = 1'b0;
        ext_trig     = 1'b0;
    endtask

    // Output monitor: consumes the expected stream on every accepted transfer.
    always @(negedge clk) begin
        if (hold_pending) begin
            chk("hold_valid", 64'(rd_valid), 64'(1));
            if (rd_valid) chk("hold_data", 64'(rd_data), 64'(held));
        end
        hold_pending = 1'b0;
        if (reset_n && !arm && rd_valid) begin
            if (rd_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_xfer: got 0x%0h expected no transfer", rd_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(mon_exp));
                    chk("rd_last", 64'(rd_last), 64'(exp_q.size() == 0));
                end
            end else begin
                hold_pending = 1'b1;
                held         = rd_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset_n    = 1'b0;
        trig_pc_en = 1'b0;
        trig_pc    = '0;
        post_count = '0;
        quiet_inputs();
        tick();
        tick();
        chk("reset_rd_data", 64'(rd_data), 64'(0));
        chk("reset_rd_last", 64'(rd_last), 64'(0));
        reset_n = 1'b1;

        // Ten samples, external trigger on the last one, no post-trigger samples.
        arm_pulse();
        for (int i = 0; i < 10; i++) sample(i, i == 9);
        chk("A_state_done", 64'(state), 64'(S_DONE));
        chk("A_count", 64'(entry_count), 64'(10));
        drain(0);

        // Overflow: 100 samples into 64 entries, PC-match trigger on pc=99.
        trig_pc_en = 1'b1;
        trig_pc    = PC_W'(99);
        arm_pulse();
        for (int i = 0; i < 100; i++) sample(i, 1'b0);
        chk("B_count_full", 64'(entry_count), 64'(64));
        chk("B_state_done", 64'(state), 64'(S_DONE));
        drain(0);

        // PC trigger at 5 with three post-trigger samples, stalled consumer.
        trig_pc    = PC_W'(5);
        post_count = AW'(3);
        arm_pulse();
        for (int i = 0; i < 9; i++) sample(i, 1'b0);
        chk("C_state_done", 64'(state), 64'(S_DONE));
        chk("C_count", 64'(entry_count), 64'(9));
        sample(9, 1'b0);
        chk("C_state_drain", 64'(state), 64'(S_DRAIN));
        for (int i = 10; i < 13; i++) sample(i, 1'b0);
        drain(1);

        // Re-arm in the middle of a drain.
        trig_pc_en = 1'b0;
        post_count = '0;
        arm_pulse();
        for (int i = 0; i < 8; i++) sample(i + 100, i == 7);
        rd_ready = 1'b1;
        tick();
        tick();
        tick();
        rd_ready = 1'b0;
        arm_pulse();
        chk("D_rd_valid", 64'(rd_valid), 64'(0));
        chk("D_state", 64'(state), 64'(S_CAPTURE));
        chk("D_count", 64'(entry_count), 64'(0));
        for (int i = 0; i < 5; i++) sample(i + 20, i == 4);
        drain(2);

        // Reset while collecting post-trigger samples.
        post_count = AW'(5);
        arm_pulse();
        for (int i = 0; i < 4; i++) sample(i, i == 2);
        chk("E_state_post", 64'(state), 64'(S_POST));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("E_rd_data", 64'(rd_data), 64'(0));
        chk("E_rd_last", 64'(rd_last), 64'(0));
        for (int i = 0; i < 4; i++) sample(i, 1'b1);
        chk("E_state_idle", 64'(state), 64'(S_IDLE));
        chk("E_count", 64'(entry_count), 64'(0));

        // Randomized capture/drain rounds.
        for (int r = 0; r < 25; r++) begin
            sample_valid = 1'($urandom_range(0, 1));
            pc           = PC_W'($urandom_range(0, 40));
            rand_payload();
            arm_pulse();
            trig_pc_en = 1'($urandom_range(0, 1));
            trig_pc    = PC_W'($urandom_range(0, 40));
            post_count = AW'($urandom_range(0, DEPTH - 1));
            k = 0;
            while ((m_state == S_CAPTURE || m_state == S_POST) && k < 400) begin
                sample_valid = ($urandom_range(0, 3) != 0);
                pc           = PC_W'($urandom_range(0, 40));
                ext_trig     = ($urandom_range(0, 49) == 0);
                rand_payload();
                if (k >= 200 && m_state == S_CAPTURE) begin
                    sample_valid = 1'b1;
                    ext_trig     = 1'b1;
                end
                tick();
                k++;
            end
            quiet_inputs();
            if (m_state == S_CAPTURE || m_state == S_POST) begin
                n_checks++;
                n_errors++;
                $display("FAIL capture_timeout: got model state %0d expected %0d", m_state, S_DONE);
            end
            drain(2);
        end

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
